flow_rate_scheduler: RTL and testbench

// - Central rate scheduler for the packet generator. Replaces per-flow free-running timers.
// - Holds one fixed-point byte-credit bucket per flow and picks one eligible flow round-robin.
// - Issues one packet command (flow index + size) per handshake to the command-FIFO writer.
// - Per-flow packet size, credit increment and enable come from flat configuration vectors.

---
 rtl/pktgen_pkg.sv | 18 +
 rtl/flow_rate_scheduler_rr_pick.sv | 34 +++
 rtl/flow_rate_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_flow_rate_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pktgen_pkg.sv
// Shared definitions for the packet generator rate scheduler.
//   FRAC_BITS     : fractional bits of the byte-credit fixed-point format
//   sched_state_t : scheduler FSM states
//   credit_cost() : packet size in bytes -> fixed-point credit cost
package pktgen_pkg;

  localparam int unsigned FRAC_BITS = 8;

  typedef enum logic {
    SCAN,
    OFFER
  } sched_state_t;

  function automatic logic [31:0] credit_cost(input logic [31:0] size);
    return size << FRAC_BITS;
  endfunction

endpackage

// File: rtl/flow_rate_scheduler_rr_pick.sv
// rr_pick: combinational round-robin first-one finder.
//   req : per-flow request vector
//   ptr : search start index (first candidate considered)
//   any : at least one request is set
//   idx : first requesting index at or after ptr, wrapping N_FLOWS-1 -> 0
module rr_pick #(
  parameter int unsigned N_FLOWS = 4,
  parameter int unsigned FLOW_W  = 2
) (
  input  logic [N_FLOWS-1:0] req,
  input  logic [FLOW_W-1:0]  ptr,
  output logic               any,
  output logic [FLOW_W-1:0]  idx
);

  int unsigned j;

  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int unsigned k = 0; k < N_FLOWS; k++) begin
      j = 32'(ptr) + k;
      if (j >= N_FLOWS) begin
        j = j - N_FLOWS;
      end
      if (!any && req[FLOW_W'(j)]) begin
        any = 1'b1;
        idx = FLOW_W'(j);
      end
    end
  end

endmodule

// File: rtl/flow_rate_scheduler.sv
// flow_rate_scheduler: per-flow fixed-point byte-credit buckets with a
// round-robin picker; issues one (flow, size) command per valid/ready handshake.
//   clk, rst    : clock, synchronous active-high reset
//   cfg_enable  : per-flow enable
//   cfg_size    : per-flow packet bytes, flow i at [SIZE_WIDTH*i +: SIZE_WIDTH]
//   cfg_inc     : per-flow credit added per cycle (FRAC_BITS fractional bits)
//   sched_valid / sched_ready / sched_flow / sched_size : command handshake
//   credit_ovf  : sticky per-flow flag, bucket clamped at its cap
//   stat_pkts   : per-flow accepted-command counters (only with FLOW_SCHED_STATS_EN)
// Optional feature macro: FLOW_SCHED_STATS_EN
module flow_rate_scheduler
  import pktgen_pkg::*;
#(
  parameter  int unsigned N_FLOWS      = 4,
  parameter  int unsigned SIZE_WIDTH   = 11,
  parameter  int unsigned INC_WIDTH    = 20,
  parameter  int unsigned CREDIT_WIDTH = 32,
  parameter  int unsigned BURST_PKTS   = 4,
  localparam int unsigned FLOW_W       = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_FLOWS-1:0]              cfg_enable,
  input  logic [N_FLOWS*SIZE_WIDTH-1:0]   cfg_size,
  input  logic [N_FLOWS*INC_WIDTH-1:0]    cfg_inc,
  output logic                            sched_valid,
  input  logic                            sched_ready,
  output logic [FLOW_W-1:0]               sched_flow,
  output logic [SIZE_WIDTH-1:0]           sched_size,
  output logic [N_FLOWS-1:0]              credit_ovf
`ifdef FLOW_SCHED_STATS_EN
  ,
  output logic [N_FLOWS*32-1:0]           stat_pkts
`endif
);

  localparam int unsigned CW1 = CREDIT_WIDTH + 1;

  sched_state_t            state_q, state_d;
  logic [FLOW_W-1:0]       flow_q, flow_d;
  logic [SIZE_WIDTH-1:0]   size_q, size_d;
  logic [FLOW_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] credit_q [N_FLOWS];
  logic [CREDIT_WIDTH-1:0] credit_d [N_FLOWS];
  logic [N_FLOWS-1:0]      ovf_q, ovf_d;

  logic [SIZE_WIDTH-1:0]   size_w [N_FLOWS];
  logic [INC_WIDTH-1:0]    inc_w  [N_FLOWS];
  logic [CW1-1:0]          cost_w [N_FLOWS];
  logic [CW1-1:0]          cap_w  [N_FLOWS];
  logic [N_FLOWS-1:0]      eligible;
  logic                    pick_any;
  logic [FLOW_W-1:0]       pick_idx;
  logic                    handshake;
  logic                    withdraw;
  logic [CW1-1:0]          sum_w;
  logic [CW1-1:0]          ded_w;
  logic [CW1-1:0]          net_w;

  // Unpack configuration and derive per-flow cost, cap and eligibility.
  always_comb begin
    for (int unsigned i = 0; i < N_FLOWS; i++) begin
      size_w[i]   = cfg_size[SIZE_WIDTH*i +: SIZE_WIDTH];
      inc_w[i]    = cfg_inc[INC_WIDTH*i +: INC_WIDTH];
      cost_w[i]   = CW1'(credit_cost(32'(size_w[i])));
      cap_w[i]    = CW1'(BURST_PKTS) * cost_w[i];
      eligible[i] = cfg_enable[i] && (size_w[i] != '0) &&
                    ({1'b0, credit_q[i]} >= cost_w[i]);
    end
  end

  rr_pick #(
    .N_FLOWS (N_FLOWS),
    .FLOW_W  (FLOW_W)
  ) u_rr_pick (
    .req (eligible),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // A handshake that coincides with the disable still completes: downstream
  // has already taken the command, so only an unaccepted offer is withdrawn.
  assign handshake = (state_q == OFFER) && sched_ready;
  assign withdraw  = (state_q == OFFER) && !sched_ready && !cfg_enable[flow_q];

  // State register (all flops).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCAN;
      flow_q   <= '0;
      size_q   <= '0;
      rr_ptr_q <= '0;
      ovf_q    <= '0;
      for (int unsigned i = 0; i < N_FLOWS; i++) begin
        credit_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      flow_q   <= flow_d;
      size_q   <= size_d;
      rr_ptr_q <= rr_ptr_d;
      ovf_q    <= ovf_d;
      for (int unsigned i = 0; i < N_FLOWS; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (pick_any) state_d = OFFER;
      OFFER:   if (handshake || withdraw) state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  // Datapath next values: latched command, rr pointer and credit buckets.
  always_comb begin
    flow_d   = flow_q;
    size_d   = size_q;
    rr_ptr_d = rr_ptr_q;
    ovf_d    = ovf_q;
    sum_w    = '0;
    ded_w    = '0;
    net_w    = '0;

    if (state_q == SCAN && pick_any) begin
      flow_d = pick_idx;
      size_d = size_w[pick_idx];
    end

    if (handshake) begin
      rr_ptr_d = (flow_q == FLOW_W'(N_FLOWS - 1)) ? '0 : flow_q + FLOW_W'(1);
    end

    for (int unsigned i = 0; i < N_FLOWS; i++) begin
      credit_d[i] = '0;
      if (cfg_enable[i]) begin
        sum_w = {1'b0, credit_q[i]} + CW1'(inc_w[i]);
        // Deduct the cost of the size actually sent, not the live config.
        ded_w = (handshake && flow_q == FLOW_W'(i)) ?
                CW1'(credit_cost(32'(size_q))) : '0;
        net_w = (sum_w >= ded_w) ? (sum_w - ded_w) : '0;
        if (net_w > cap_w[i]) begin
          credit_d[i] = cap_w[i][CREDIT_WIDTH-1:0];
          ovf_d[i]    = 1'b1;
        end else begin
          credit_d[i] = net_w[CREDIT_WIDTH-1:0];
        end
      end
    end
  end

  // Output logic.
  always_comb begin
    sched_valid = (state_q == OFFER);
    sched_flow  = flow_q;
    sched_size  = size_q;
    credit_ovf  = ovf_q;
  end

`ifdef FLOW_SCHED_STATS_EN
  logic [31:0] stat_q [N_FLOWS];
  logic [31:0] stat_d [N_FLOWS];

  always_comb begin
    for (int unsigned i = 0; i < N_FLOWS; i++) begin
      stat_d[i] = stat_q[i];
      if (handshake && flow_q == FLOW_W'(i)) begin
        stat_d[i] = stat_q[i] + 32'd1;
      end
      stat_pkts[32*i +: 32] = stat_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_FLOWS; i++) begin
      if (rst) begin
        stat_q[i] <= '0;
      end else begin
        stat_q[i] <= stat_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_flow_rate_scheduler.sv
// Self-checking bench for flow_rate_scheduler (N_FLOWS=4, FRAC_BITS=8).
// A per-cycle reference model built from the credit/round-robin rules is
// compared against every DUT output, plus directed latency/fairness checks.
module tb_flow_rate_scheduler;

  localparam int N  = 4;
  localparam int SW = 11;
  localparam int IW = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cfg_enable;
  logic [N*SW-1:0] cfg_size;
  logic [N*IW-1:0] cfg_inc;
  logic            sched_valid;
  logic            sched_ready;
  logic [1:0]      sched_flow;
  logic [SW-1:0]   sched_size;
  logic [N-1:0]    credit_ovf;
`ifdef FLOW_SCHED_STATS_EN
  logic [N*32-1:0] stat_pkts;
`endif

  flow_rate_scheduler #(
    .N_FLOWS      (4),
    .SIZE_WIDTH   (11),
    .INC_WIDTH    (20),
    .CREDIT_WIDTH (32),
    .BURST_PKTS   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_enable  (cfg_enable),
    .cfg_size    (cfg_size),
    .cfg_inc     (cfg_inc),
    .sched_valid (sched_valid),
    .sched_ready (sched_ready),
    .sched_flow  (sched_flow),
    .sched_size  (sched_size),
    .credit_ovf  (credit_ovf)
`ifdef FLOW_SCHED_STATS_EN
    ,
    .stat_pkts   (stat_pkts)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bench-side configuration.
  bit en  [N];
  int sz  [N];
  int inc [N];

  task automatic push_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_enable[i]         = en[i];
      cfg_size[i*SW +: SW]  = SW'(sz[i]);
      cfg_inc[i*IW +: IW]   = IW'(inc[i]);
    end
  endtask

  task automatic set_all(input bit e, input int s, input int c);
    for (int i = 0; i < N; i++) begin
      en[i] = e; sz[i] = s; inc[i] = c;
    end
    push_cfg();
  endtask

  // Reference model: bucket arithmetic in wide signed integers.
  bit      m_offer;
  int      m_flow, m_size, m_ptr;
  longint  m_cred [N];
  bit      m_ovf  [N];
  longint  m_stat [N];

  function automatic void model_step();
    bit     hs, wd, found;
    bit     elig [N];
    longint c, cap;
    if (rst) begin
      m_offer = 0; m_flow = 0; m_size = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) begin
        m_cred[i] = 0; m_ovf[i] = 0; m_stat[i] = 0;
      end
      return;
    end
    hs = m_offer && sched_ready;
    wd = m_offer && !sched_ready && !en[m_flow];
    for (int i = 0; i < N; i++)
      elig[i] = en[i] && sz[i] != 0 && m_cred[i] >= longint'(sz[i]) * 256;
    for (int i = 0; i < N; i++) begin
      if (!en[i]) begin
        m_cred[i] = 0;
      end else begin
        c = m_cred[i] + inc[i] - ((hs && m_flow == i) ? longint'(m_size) * 256 : 0);
        if (c < 0) c = 0;
        cap = 4 * longint'(sz[i]) * 256;
        if (c > cap) begin
          c = cap;
          m_ovf[i] = 1;
        end
        m_cred[i] = c;
      end
    end
    if (!m_offer) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && elig[j]) begin
          found = 1; m_offer = 1; m_flow = j; m_size = sz[j];
        end
      end
    end else if (hs) begin
      m_stat[m_flow] = (m_stat[m_flow] + 1) % (64'd1 << 32);
      m_ptr   = (m_flow + 1) % N;
      m_offer = 0;
    end else if (wd) begin
      m_offer = 0;
    end
  endfunction

  task automatic compare_all();
    check_eq("valid", 64'(sched_valid), 64'(m_offer));
    check_eq("flow",  64'(sched_flow),  64'(m_flow));
    check_eq("size",  64'(sched_size),  64'(m_size));
    for (int i = 0; i < N; i++)
      check_eq("ovf", 64'(credit_ovf[i]), 64'(m_ovf[i]));
`ifdef FLOW_SCHED_STATS_EN
    for (int i = 0; i < N; i++)
      check_eq("stat", 64'(stat_pkts[32*i +: 32]), 64'(m_stat[i]));
`endif
  endtask

  int grant_q [$];

  // One clock: note the pending handshake, advance the model, compare.
  task automatic tick();
    bit pre_hs;
    int pre_flow;
    pre_hs   = sched_valid && sched_ready;
    pre_flow = int'(sched_flow);
    @(posedge clk);
    model_step();
    #1;
    if (pre_hs) grant_q.push_back(pre_flow);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_valid", 64'(sched_valid), 64'd0);
    check_eq("rst_flow",  64'(sched_flow),  64'd0);
    check_eq("rst_size",  64'(sched_size),  64'd0);
    check_eq("rst_ovf",   64'(credit_ovf),  64'd0);
    rst = 1'b0;
    grant_q.delete();
  endtask

  initial begin
    int  first, last_rise, cnt;
    bit  prev_v, found;

    rst = 1'b1;
    sched_ready = 1'b0;
    set_all(0, 0, 0);
    do_reset();

    // Single flow: 1 B/cycle, 64-byte packets.
    sz[0] = 64; inc[0] = 'h100; en[0] = 1; push_cfg();
    sched_ready = 1'b1;
    first = -1; last_rise = -1; prev_v = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (sched_valid && !prev_v) begin
        if (first < 0) begin
          first = k;
          check_eq("first_valid_lat", 64'(k), 64'd65);
        end else begin
          check_eq("grant_period", 64'(k - last_rise), 64'd64);
        end
        last_rise = k;
      end
      prev_v = sched_valid;
    end
    check_eq("single_grants", 64'(grant_q.size()), 64'd4);

    // Fairness: all flows always eligible.
    do_reset();
    set_all(1, 64, 'h4000);
    sched_ready = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    check_eq("fair_count", 64'(grant_q.size() >= 16), 64'd1);
    foreach (grant_q[j]) check_eq("fair_order", 64'(grant_q[j]), 64'(j % 4));

    // Backpressure: bucket saturates, then one burst drains.
    do_reset();
    set_all(0, 64, 0);
    en[0] = 1; inc[0] = 'h100; push_cfg();
    sched_ready = 1'b0;
    for (int k = 0; k < 300; k++) tick();
    check_eq("bp_valid", 64'(sched_valid), 64'd1);
    check_eq("bp_ovf",   64'(credit_ovf[0]), 64'd1);
    sched_ready = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    check_eq("bp_burst", 64'(grant_q.size()), 64'd4);

    // Disable flow 2 while it is offered.
    do_reset();
    set_all(1, 64, 'h4000);
    sched_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      if (sched_valid && sched_flow == 2'd2) found = 1;
    end
    check_eq("wd_offer_seen", 64'(found), 64'd1);
    sched_ready = 1'b0;
    en[2] = 0; push_cfg();
    tick();
    check_eq("wd_valid_drop", 64'(sched_valid), 64'd0);
    sched_ready = 1'b1;
    grant_q.delete();
    for (int k = 0; k < 80; k++) tick();
    cnt = 0;
    foreach (grant_q[j]) if (grant_q[j] == 2) cnt++;
    check_eq("wd_flow2_never", 64'(cnt), 64'd0);
    check_eq("wd_others_run", 64'(grant_q.size() > 10), 64'd1);

    // Reset while offering flow 1.
    set_all(1, 64, 'h4000);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      if (sched_valid && sched_flow == 2'd1) found = 1;
    end
    check_eq("mid_offer_seen", 64'(found), 64'd1);
    sched_ready = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("mid_rst_valid", 64'(sched_valid), 64'd0);
    check_eq("mid_rst_flow",  64'(sched_flow),  64'd0);
    check_eq("mid_rst_size",  64'(sched_size),  64'd0);
    rst = 1'b0;
    sched_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (sched_valid) begin
        found = 1;
        check_eq("post_rst_flow", 64'(sched_flow), 64'd0);
      end
    end
    check_eq("post_rst_seen", 64'(found), 64'd1);

    // Randomized configurations, backpressure and live cfg changes.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        en[i]  = ($urandom_range(0, 3) != 0);
        sz[i]  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 96));
        inc[i] = int'($urandom_range(0, 'h3000));
      end
      push_cfg();
      for (int k = 0; k < 400; k++) begin
        sched_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 49) == 0) begin
          int f;
          f = int'($urandom_range(0, N - 1));
          en[f]  = ~en[f];
          sz[f]  = int'($urandom_range(0, 96));
          inc[f] = int'($urandom_range(0, 'h8000));
          push_cfg();
        end
        tick();
      end
    end

`ifdef FLOW_SCHED_STATS_EN
    // Stats: exactly 10 accepted flow-1 commands.
    do_reset();
    set_all(0, 64, 0);
    en[1] = 1; inc[1] = 'h4000; push_cfg();
    sched_ready = 1'b1;
    for (int k = 0; k < 100 && grant_q.size() < 10; k++) begin
      tick();
      if (grant_q.size() >= 10) sched_ready = 1'b0;
    end
    for (int k = 0; k < 4; k++) tick();
    check_eq("stat_flow1", 64'(stat_pkts[63:32]), 64'd10);
    check_eq("stat_flow0", 64'(stat_pkts[31:0]),  64'd0);
    check_eq("stat_flow2", 64'(stat_pkts[95:64]), 64'd0);
    check_eq("stat_flow3", 64'(stat_pkts[127:96]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
